// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mult_div_unit                                                 |
// | Purpose  : Iterative 32-bit multiply/divide unit with HI/LO result       |
// |            registers. MULT/MULTU use shift-add on a 64-bit accumulator,  |
// |            DIV/DIVU use restoring shift-subtract with a 33-bit partial   |
// |            remainder; both share one adder. Signed operations run on     |
// |            magnitudes and are sign-corrected in a final FIX cycle.       |
// |            MTHI/MTLO writes are accepted only while idle.                |
// | Option   : `define MDU_FAST_ZERO_EN to let multiply-by-zero and          |
// |            divide-by-zero skip the iterative phase (done at E1).         |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)           |
// |            inA, inB      operands (multiplicand/dividend, mult./divisor) |
// |            hiWe, loWe, wrData   MTHI/MTLO write port                     |
// |            busy, done    status (never high together)                    |
// |            hi, lo        result registers                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int       c_DW       = 2 * WIDTH;
  localparam logic [5:0] c_CNT_LAST = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t            state_q;
  logic [5:0]        cnt_q;
  logic              is_div_q;
  logic              neg_res_q;   // negate product / quotient
  logic              neg_rem_q;   // negate remainder (dividend was negative)
  logic              dz_q;        // divide by zero
  logic [WIDTH-1:0]  b_q;         // |multiplicand| or |divisor|
  logic [c_DW-1:0]   acc_q;       // {hi part / remainder, multiplier / quotient}
  logic [c_DW-1:0]   acc_d;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  // ---------------------------------------------------------------------
  // Launch decode (used only in IDLE)
  // ---------------------------------------------------------------------
  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             fast_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    a_neg     = op_signed & inA[WIDTH-1];
    b_neg     = op_signed & inB[WIDTH-1];
    abs_a     = a_neg ? (~inA + 1'b1) : inA;
    abs_b     = b_neg ? (~inB + 1'b1) : inB;
    b_zero    = (inB == '0);
`ifdef MDU_FAST_ZERO_EN
    fast_zero = op_div ? b_zero : (b_zero | (inA == '0));
`else
    fast_zero = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // Shared iteration datapath: one (WIDTH+2)-bit adder.
  // Multiply: add |B| into the upper half when the multiplier LSB is set,
  //           then shift the whole accumulator right.
  // Divide:   shift the next dividend bit into the partial remainder and
  //           try subtracting |B| (add ~B with carry-in); a carry out means
  //           no borrow, so the difference is kept and a 1 enters the
  //           quotient at the bottom.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   addend;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;

  always_comb begin
    partial   = is_div_q ? acc_q[c_DW-1:WIDTH-1] : {1'b0, acc_q[c_DW-1:WIDTH]};
    addend    = is_div_q ? ~{1'b0, b_q} : (acc_q[0] ? {1'b0, b_q} : '0);
    sum       = {1'b0, partial} + {1'b0, addend} + {{(WIDTH+1){1'b0}}, is_div_q};
    no_borrow = sum[WIDTH+1];
    if (is_div_q) begin
      // A failed trial leaves partial < |B| < 2^WIDTH, so partial[WIDTH] is 0.
      acc_d = {(no_borrow ? sum[WIDTH-1:0] : partial[WIDTH-1:0]),
               acc_q[WIDTH-2:0], no_borrow};
    end else begin
      acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------
  // Sign correction for the FIX cycle.
  // Divide by zero: the restoring loop subtracts zero every step, so the
  // remainder ends as |inA|; re-applying the dividend sign restores the
  // original inA, which is exactly the required HI value. Only LO needs an
  // override.
  // ---------------------------------------------------------------------
  logic [c_DW-1:0]  prod_fix;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[c_DW-1:WIDTH];
    if (is_div_q) begin
      res_hi = neg_rem_q ? (~rem + 1'b1) : rem;
      res_lo = dz_q ? '1 : (neg_res_q ? (~quo + 1'b1) : quo);
    end else begin
      res_hi = prod_fix[c_DW-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM and all state registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // start takes priority; any MTHI/MTLO in this cycle is dropped
            is_div_q  <= op_div;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= op_div & b_zero;
            b_q       <= abs_b;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (fast_zero) begin
              // Preload what the full loop would have produced.
              acc_q   <= op_div ? {abs_a, {WIDTH{1'b0}}} : '0;
              state_q <= ST_FIX;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, abs_a};
              state_q <= ST_RUN;
            end
          end else begin
            if (hiWe) hi_q <= wrData;
            if (loWe) lo_q <= wrData;
          end
        end

        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == c_CNT_LAST) begin
            state_q <= ST_FIX;
          end
        end

        ST_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_mult_div_unit                                              |
// | Purpose  : Scoreboard bench for mult_div_unit. Stimulus pushes expected  |
// |            {hi, lo, latency}; a negedge monitor pops and compares on     |
// |            every done pulse, also checking busy length and busy/done     |
// |            exclusivity.                                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mult_div_unit;

  localparam int c_FULL = 33;
`ifdef MDU_FAST_ZERO_EN
  localparam int c_ZLAT = 1;
`else
  localparam int c_ZLAT = 33;
`endif

  localparam logic [1:0] c_MULT  = 2'b00;
  localparam logic [1:0] c_MULTU = 2'b01;
  localparam logic [1:0] c_DIV   = 2'b10;
  localparam logic [1:0] c_DIVU  = 2'b11;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [1:0]  op     = 2'b00;
  logic [31:0] inA    = '0;
  logic [31:0] inB    = '0;
  logic        hiWe   = 1'b0;
  logic        loWe   = 1'b0;
  logic [31:0] wrData = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .inA    (inA),
    .inB    (inB),
    .hiWe   (hiWe),
    .loWe   (loWe),
    .wrData (wrData),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   neg_cnt    = 0;
  int   launch_neg = 0;
  int   busy_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    neg_cnt++;
    if (rst_n) begin
      if (done) begin
        chk("busy_with_done", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("latency", 32'(neg_cnt - launch_neg - 1), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
      end
      if (busy) busy_cnt++;
      if (start && !busy) begin
        launch_neg = neg_cnt;
        busy_cnt   = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    @(posedge clk); #1;
    op = o; inA = a; inB = b; start = 1'b1;
    e.hi = eh; e.lo = el; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;          // this edge is E0
    start = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int lat);
    launch(o, a, b, eh, el, lat);
    wait_done();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // multiply
    run(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, c_FULL);
    run(c_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, c_FULL);
    run(c_MULTU, 32'h5555_5555, 32'd3,         32'h0000_0000, 32'hFFFF_FFFF, c_FULL);
    run(c_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, c_FULL);
    run(c_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, c_FULL);
    run(c_MULT,  32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000, c_ZLAT);

    // divide
    run(c_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, c_FULL);
    run(c_DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, c_FULL);
    run(c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, c_FULL);
    run(c_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, c_FULL);
    run(c_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, c_FULL);
    run(c_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, c_FULL);

    // divide by zero
    run(c_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, c_ZLAT);
    run(c_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, c_ZLAT);

    // start and MTHI while busy are ignored
    launch(c_MULTU, 32'hAAAA_AAAA, 32'd2, 32'h0000_0001, 32'h5555_5554, c_FULL);
    repeat (9) @(posedge clk);
    #1;                                   // between E9 and E10
    op = c_DIVU; inA = 32'd100; inB = 32'd7; start = 1'b1;
    hiWe = 1'b1; wrData = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hiWe = 1'b0;
    wait_done();

    // MTLO in IDLE
    @(posedge clk); #1;
    loWe = 1'b1; wrData = 32'hCAFE_F00D;
    @(posedge clk); #1;
    loWe = 1'b0;
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi_kept", hi, 32'h0000_0001);

    // MTHI and MTLO together
    hiWe = 1'b1; loWe = 1'b1; wrData = 32'h1111_2222;
    @(posedge clk); #1;
    hiWe = 1'b0; loWe = 1'b0;
    chk("mthi_both", hi, 32'h1111_2222);
    chk("mtlo_both", lo, 32'h1111_2222);

    // asynchronous reset mid-divide
    launch(c_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, c_FULL);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // start wins over a simultaneous MTLO
    @(posedge clk); #1;
    op = c_MULTU; inA = 32'd2; inB = 32'd3; start = 1'b1;
    loWe = 1'b1; wrData = 32'h0BAD_0BAD;
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd6; e.lat = c_FULL;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; loWe = 1'b0;
    wait_done();

    repeat (4) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit with HI/LO result registers.
- Sits in the execute stage beside the 32-bit AND/OR gate datapath and receives the same operand buses (inA, inB).
- Serves MULT, MULTU, DIV, DIVU using one shared shift/add-subtract datapath, plus MTHI/MTLO writes.
- The control unit stalls the pipeline on busy and reads HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and result width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
inA  input  32  multiplicand / dividend
inB  input  32  multiplier / divisor
hiWe  input  1  MTHI write enable
loWe  input  1  MTLO write enable
wrData  input  32  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO updated
hi  output  32  HI register (product[63:32] / remainder)
lo  output  32  LO register (product[31:0] / quotient)

Behaviour:
- Reset: clk, async active-low rst_n (already decided). rst_n low forces, immediately and regardless of clk: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0. Reset mid-operation discards the operation; no partial HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0 latches op, |inA|, |inB| (magnitudes for signed ops; raw values for unsigned), result sign, and remainder sign.
  - busy=1 from E0 onward; go to RUN.
- RUN: one iteration per cycle, 32 iterations (edges E1..E32); 6-bit counter; go to FIX after the 32nd iteration.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract; 33-bit partial remainder.
- FIX, edge E33:
  - Apply sign correction and write hi/lo.
  - done=1 for exactly the cycle E33..E34; busy=0 at E33; return to IDLE.
  - Total latency: start edge to done rising = 33 edges.
- Signed rules:
  - Product is negated if operand signs differ.
  - Quotient is negated if operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops take no correction.
- Divide by zero (DIV or DIVU, inB=0): lo=32'hFFFF_FFFF, hi=inA as latched (original signed value for DIV). Same latency.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (wraps, no trap).
- start while busy=1: ignored, no effect on the running operation.
- hiWe/loWe:
  - In IDLE, the write takes effect on the next edge; hiWe and loWe may both be set in the same cycle.
  - Ignored while busy=1.
  - Same IDLE cycle as start=1: start wins, write dropped.
- done and busy are never high in the same cycle. hi/lo hold their values between operations.

Optional Feature:
- Macro MDU_FAST_ZERO_EN.
- Defined:
  - In IDLE, the unit checks for multiply with inA=0 or inB=0, or divide with inB=0.
  - On any of these, it skips RUN and goes IDLE->FIX: hi/lo written and done pulsed at E1, busy high only E0..E1.
  - Result values are identical to the full path (0/0 for multiply; divide-by-zero values above).
- Undefined: every operation takes the full 33-edge latency.

Test Plan:
1. MULTU inA=0xFFFF_FFFF, inB=0xFFFF_FFFF, start pulse -> done exactly 33 edges later; hi=0xFFFF_FFFE, lo=0x0000_0001; busy high for 33 cycles.
2. MULT inA=0xFFFF_FFFD (-3), inB=5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. MULTU 0x5555_5555 x 3 -> hi=0, lo=0xFFFF_FFFF.
3. DIV inA=0xFFFF_FFF9 (-7), inB=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
4. DIVU inA=0x1234_5678, inB=0 -> lo=0xFFFF_FFFF, hi=0x1234_5678. Latency 33 edges, or 1 edge with MDU_FAST_ZERO_EN.
5. Start MULTU 0xAAAA_AAAA x 2; at E10 pulse start with new operands and hiWe=1, wrData=0xDEAD_BEEF -> both ignored; result hi=1, lo=0x5555_5554. Then in IDLE: loWe=1, wrData=0xCAFE_F00D -> lo=0xCAFE_F00D next edge, hi unchanged.
6. Start DIV, drop rst_n at E15 between edges -> busy, done, hi, lo go to 0 immediately. Release rst_n and start MULTU 2x3 -> lo=6, hi=0 after 33 edges.
